// File: rtl/program_counter_stack.sv
// program_counter_stack: fetch-stage PC with an integrated return-address stack.
// Define PC_STACK_TRAP_EN to vector stack overflow/underflow to TRAP_ADDR.
module program_counter_stack #(
  parameter int ADDR_WIDTH = 20,
  parameter int STACK_DEPTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_ADDR = 20'hFFFF0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [2:0]                         flagPC,
  input  logic [ADDR_WIDTH-1:0]              newAddress,
  input  logic                               clearFlags,
  output logic [ADDR_WIDTH-1:0]              address,
  output logic [ADDR_WIDTH-1:0]              topAddress,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stackDepth,
  output logic                               stackFull,
  output logic                               stackEmpty,
  output logic                               stackOverflow,
  output logic                               stackUnderflow
);
  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int IW = $clog2(STACK_DEPTH);
`ifdef PC_STACK_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  logic [ADDR_WIDTH-1:0] address_q, address_d, next_seq;
  logic [DW-1:0]         depth_q, depth_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic                  full, empty, call, ret, push;
  logic [IW-1:0]         wr_idx, rd_idx;
  logic [ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  assign full     = depth_q == DW'(STACK_DEPTH);
  assign empty    = depth_q == '0;
  assign call     = flagPC == 3'd4;
  assign ret      = flagPC == 3'd5;
  assign push     = call && !full;
  assign next_seq = address_q + 1'b1;
  assign wr_idx   = IW'(depth_q);
  assign rd_idx   = IW'(depth_q - 1'b1);
  always_comb begin
    address_d = address_q;
    depth_d   = depth_q;
    case (flagPC)
      3'd1: address_d = next_seq;
      3'd2: address_d = newAddress;
      3'd3: address_d = address_q + newAddress;
      3'd4: begin
        address_d = (full && TRAP_EN) ? TRAP_ADDR : newAddress;
        depth_d   = full ? depth_q : depth_q + 1'b1;
      end
      3'd5: begin
        address_d = !empty ? stack_q[rd_idx] : TRAP_EN ? TRAP_ADDR : address_q;
        depth_d   = empty ? depth_q : depth_q - 1'b1;
      end
      default: ;
    endcase
    // a new error in the same cycle as clearFlags wins
    overflow_d  = (call && full) || (overflow_q && !clearFlags);
    underflow_d = (ret && empty) || (underflow_q && !clearFlags);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      address_q   <= RESET_ADDR;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      address_q   <= address_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // stack storage needs no reset; entries below the pointer stay untouched on pop
  always_ff @(posedge clock) begin
    if (push) stack_q[wr_idx] <= next_seq;
  end
  assign address        = address_q;
  assign topAddress     = empty ? '0 : stack_q[rd_idx];
  assign stackDepth     = depth_q;
  assign stackFull      = full;
  assign stackEmpty     = empty;
  assign stackOverflow  = overflow_q;
  assign stackUnderflow = underflow_q;
endmodule

// File: doc/program_counter_stack.md
# program_counter_stack

Parametrised program counter with an integrated return-address stack for the processor fetch stage. It supports hold, increment, absolute jump, PC-relative branch, call (push return address and jump) and return (pop and jump). Each mode is selected per cycle by `flagPC` from the control unit. The block drives the instruction-memory address and reports stack occupancy and sticky overflow/underflow errors.

## Interface
- `ADDR_WIDTH`, 20: width of the address, `newAddress`, stack entries and `topAddress`.
- `STACK_DEPTH`, 8: number of return-address entries; must be ≥ 2.
- `RESET_ADDR`, 0: value loaded into `address` on reset.
- `TRAP_ADDR`, 20'hFFFF0: trap vector address, used only when `PC_STACK_TRAP_EN` is defined.

Ports:
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `flagPC`  in  3  mode: 0 hold, 1 increment, 2 jump, 3 relative branch, 4 call, 5 return, 6/7 hold.
- `newAddress`  in  ADDR_WIDTH  jump or call target; two's-complement offset in mode 3.
- `clearFlags`  in  1  synchronous clear of `stackOverflow` and `stackUnderflow`.
- `address`  out  ADDR_WIDTH  current PC (registered).
- `topAddress`  out  ADDR_WIDTH  entry at top of stack; 0 when empty.
- `stackDepth`  out  $clog2(STACK_DEPTH+1)  number of valid entries.
- `stackFull`  out  1  `stackDepth == STACK_DEPTH`.
- `stackEmpty`  out  1  `stackDepth == 0`.
- `stackOverflow`  out  1  sticky; set when a call occurs while full.
- `stackUnderflow`  out  1  sticky; set when a return occurs while empty.

## Operation
- **Reset state:**
  - `address` = `RESET_ADDR`; stack pointer = 0.
  - `stackOverflow` = 0; `stackUnderflow` = 0.
  - `topAddress` = 0, `stackEmpty` = 1, `stackFull` = 0, `stackDepth` = 0.
  - Stack RAM contents are don't-care.
- **Mode 0/6/7:** `address` unchanged.
- **Mode 1:** `address` ← `address` + 1, modulo 2^ADDR_WIDTH; the all-ones address wraps to 0.
- **Mode 2:** `address` ← `newAddress`.
- **Mode 3:** `address` ← `address` + `newAddress`, with `newAddress` signed and the sum modulo 2^ADDR_WIDTH. Offset 0 holds the address.
- **Mode 4 (call), not full:**
  - Push `address` + 1 (wrapped).
  - Depth +1.
  - `address` ← `newAddress`.
- **Mode 4 (call), full:** no push; depth unchanged; `stackOverflow` ← 1. The `address` update is defined under Configuration.
- **Mode 5 (return), not empty:**
  - `address` ← top entry.
  - Depth −1.
- **Mode 5 (return), empty:** depth unchanged; `stackUnderflow` ← 1. The `address` update is defined under Configuration.
- **`clearFlags`:** clears both sticky flags. If the same cycle raises a new error, set wins.
- **Stack organisation:** the stack is LIFO. Only the top entry is observable, via `topAddress`. Entries below the top are not overwritten by pops.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- Latency is 1 cycle: the `flagPC` and `newAddress` values sampled at rising edge N appear on `address` after edge N.
- `topAddress`, `stackDepth`, `stackFull` and `stackEmpty` reflect the push or pop in the same cycle that `address` changes.
- A call immediately followed by a return restores `address` to call-site + 1 after two edges.
- Reset asserted mid-stream overrides any `flagPC` value. Reset takes effect asynchronously and is released synchronously to `clock`, so the first mode is applied on the first edge after deassertion.
- A full-depth chain of calls followed by the same number of returns must unwind exactly, in LIFO order.

## Configuration
- **`PC_STACK_TRAP_EN` defined:**
  - A call while full sets `address` ← `TRAP_ADDR`.
  - A return while empty sets `address` ← `TRAP_ADDR`.
  - The stack is unchanged in both cases.
- **`PC_STACK_TRAP_EN` undefined:**
  - A call while full still jumps to `newAddress`; the return address is discarded.
  - A return while empty holds `address`.
  - The `TRAP_ADDR` parameter is unused.
- In both builds the sticky error flags behave identically.

## Test plan
- **Reset and increment:** assert reset with `flagPC`=1, release, then run 3 cycles of mode 1.
  - During reset: `address`=0.
  - Then `address` = 1, 2, 3; `stackEmpty`=1.
- **Wrap and relative branch:**
  - Jump to 20'hFFFFF, then mode 1 → `address`=0.
  - Branch with `newAddress`=20'hFFFFE (−2) → `address`=20'hFFFFE.
- **Nested calls:** at `address`=0x10, call 0x100; then call 0x200; then return twice.
  - `topAddress` shows 0x11, then 0x101.
  - `address` returns to 0x101, then 0x11.
  - `stackDepth` goes 1, 2, 1, 0.
- **Overflow:** issue 9 calls with `STACK_DEPTH`=8.
  - After the 8th call: `stackFull`=1, depth=8.
  - After the 9th call: `stackOverflow`=1 and depth stays 8.
  - `address` = the 9th target (trap off) or `TRAP_ADDR` (trap on).
- **Underflow and clear:** return on an empty stack.
  - `stackUnderflow`=1; `address` holds (or `TRAP_ADDR` with trap on).
  - Pulse `clearFlags` → flag 0.
- **Asynchronous reset mid-call:** assert reset between clock edges while depth=3.
  - Outputs go to the reset state before the next edge: `address`=`RESET_ADDR`, `stackDepth`=0, both flags 0.
